blob_motion_ctrl: RTL

- Per-frame position controller for one rectangular sprite: owns the sprite's x/y registers and advances them once per video frame by a signed velocity.
- Bounces off (or optionally wraps at) the screen edges.
- Accepts position/velocity loads from game logic via a valid/ready handshake.
- Its x/y outputs feed the sprite's combinational rectangle-draw stage; a single shared one-axis step unit is time-multiplexed over X then Y.

---
 rtl/blob_pkg.sv | 19 +
 rtl/blob_axis_step.sv | 75 +++++++
 rtl/blob_motion_ctrl.sv | 111 +++++++++++
 3 files changed

// File: rtl/blob_pkg.sv
// Shared types and constants for the blob sprite motion controller.
package blob_pkg;

  localparam int unsigned PosW           = 11;
  localparam int unsigned VelW           = 5;
  localparam int unsigned ScreenWDefault = 1024;
  localparam int unsigned ScreenHDefault = 768;

  typedef enum logic [1:0] {StIdle, StStepX, StStepY, StDone} state_e;

  // -16 has no positive counterpart in 5 bits; clamp the reflection to +15.
  function automatic logic [VelW-1:0] neg_vel(input logic [VelW-1:0] v);
    if (v == {1'b1, {(VelW-1){1'b0}}}) begin
      return {1'b0, {(VelW-1){1'b1}}};
    end
    return -v;
  endfunction

endpackage

// File: rtl/blob_axis_step.sv
// One-axis position step: advances pos by v and reflects (or wraps when
// BLOB_MOTION_WRAP_EN is defined) at the 0 / limit edges of the screen.
module blob_axis_step
  import blob_pkg::*;
(
  input  logic [PosW-1:0] pos,
  input  logic [VelW-1:0] v,
  input  logic [PosW-1:0] size,
  input  logic [PosW-1:0] limit,
  output logic [PosW-1:0] new_pos,
  output logic [VelW-1:0] new_v,
  output logic            hit
);

  // One bit wider than p needs so that p + size cannot overflow.
  localparam int unsigned IW = 14;

  logic signed [IW-1:0] pos_s, v_s, size_s, lim_s, p, reach;

  assign pos_s  = $signed({{(IW-PosW){1'b0}}, pos});
  assign v_s    = $signed({{(IW-VelW){v[VelW-1]}}, v});
  assign size_s = $signed({{(IW-PosW){1'b0}}, size});
  assign lim_s  = $signed({{(IW-PosW){1'b0}}, limit});
  assign p      = pos_s + v_s;
  assign reach  = p + size_s;

`ifdef BLOB_MOTION_WRAP_EN
  logic unused_size;
  assign unused_size = ^{size, reach[0]};

  always_comb begin
    new_pos = pos;
    new_v   = v;
    hit     = 1'b0;
    if (v != '0) begin
      if (p < 0) begin
        new_pos = PosW'(p + lim_s);
        hit     = 1'b1;
      end else if (p >= lim_s) begin
        new_pos = PosW'(p - lim_s);
        hit     = 1'b1;
      end else begin
        new_pos = PosW'(p);
      end
    end
  end
`else
  always_comb begin
    new_pos = pos;
    new_v   = v;
    hit     = 1'b0;
    if (size >= limit) begin
      // Sprite cannot fit: pin to the origin and keep reflecting if moving.
      new_pos = '0;
      if (v != '0) begin
        new_v = neg_vel(v);
        hit   = 1'b1;
      end
    end else if (v != '0) begin
      if (p < 0) begin
        new_pos = '0;
        new_v   = neg_vel(v);
        hit     = 1'b1;
      end else if (reach > lim_s) begin
        new_pos = limit - size;
        new_v   = neg_vel(v);
        hit     = 1'b1;
      end else begin
        new_pos = PosW'(p);
      end
    end
  end
`endif

endmodule

// File: rtl/blob_motion_ctrl.sv
// Per-frame sprite position controller; one shared axis step unit runs X then Y.
// Define BLOB_MOTION_WRAP_EN to wrap at screen edges instead of bouncing.
module blob_motion_ctrl
  import blob_pkg::*;
#(
  parameter int unsigned SCREEN_W = ScreenWDefault,
  parameter int unsigned SCREEN_H = ScreenHDefault,
  parameter int unsigned X_INIT   = 0,
  parameter int unsigned Y_INIT   = 0
) (
  input  logic            vclock,
  input  logic            reset,
  input  logic            vsync,
  input  logic            pause,
  input  logic [PosW-1:0] width,
  input  logic [PosW-1:0] height,
  input  logic            cfg_valid,
  output logic            cfg_ready,
  input  logic [PosW-1:0] cfg_x,
  input  logic [PosW-1:0] cfg_y,
  input  logic [VelW-1:0] cfg_vx,
  input  logic [VelW-1:0] cfg_vy,
  output logic [PosW-1:0] x,
  output logic [PosW-1:0] y,
  output logic            bounce,
  output logic            frame_done
);

  state_e          state;
  logic [PosW-1:0] x_q, y_q;
  logic [VelW-1:0] vx_q, vy_q;
  logic            vsync_d, hit_acc, bounce_q, frame_done_q;

  logic            tick, on_y, s_hit;
  logic [PosW-1:0] s_pos, s_size, s_limit, s_new_pos;
  logic [VelW-1:0] s_v, s_new_v;

  assign tick    = vsync_d & ~vsync;
  assign on_y    = (state == StStepY);
  assign s_pos   = on_y ? y_q : x_q;
  assign s_v     = on_y ? vy_q : vx_q;
  assign s_size  = on_y ? height : width;
  assign s_limit = on_y ? PosW'(SCREEN_H) : PosW'(SCREEN_W);

  blob_axis_step u_step (
    .pos    (s_pos),
    .v      (s_v),
    .size   (s_size),
    .limit  (s_limit),
    .new_pos(s_new_pos),
    .new_v  (s_new_v),
    .hit    (s_hit)
  );

  always_ff @(posedge vclock) begin
    if (reset) begin
      state        <= StIdle;
      x_q          <= PosW'(X_INIT);
      y_q          <= PosW'(Y_INIT);
      vx_q         <= '0;
      vy_q         <= '0;
      vsync_d      <= 1'b1;
      hit_acc      <= 1'b0;
      bounce_q     <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      // Edges seen outside IDLE are consumed here and never acted on.
      vsync_d      <= vsync;
      bounce_q     <= 1'b0;
      frame_done_q <= 1'b0;
      unique case (state)
        StIdle: begin
          if (cfg_valid) begin
            x_q  <= cfg_x;
            y_q  <= cfg_y;
            vx_q <= cfg_vx;
            vy_q <= cfg_vy;
          end else if (tick && !pause) begin
            hit_acc <= 1'b0;
            state   <= StStepX;
          end
        end
        StStepX: begin
          x_q     <= s_new_pos;
          vx_q    <= s_new_v;
          hit_acc <= s_hit;
          state   <= StStepY;
        end
        StStepY: begin
          y_q     <= s_new_pos;
          vy_q    <= s_new_v;
          hit_acc <= hit_acc | s_hit;
          state   <= StDone;
        end
        StDone: begin
          frame_done_q <= 1'b1;
          bounce_q     <= hit_acc;
          state        <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

  assign cfg_ready  = (state == StIdle);
  assign x          = x_q;
  assign y          = y_q;
  assign bounce     = bounce_q;
  assign frame_done = frame_done_q;

endmodule
